// File: rtl/roce_tx_transfer_scheduler.sv
// ---------------------------------------------------------------------------
// roce_tx_transfer_scheduler
//
// Splits one RDMA WRITE transfer into a sequence of packet descriptors
// (FIRST / MIDDLE / LAST, or a single ONLY). A transfer starts on the
// rising edge of start_transfer. Each descriptor is presented on a
// valid/ready handshake. The PSN and the remote virtual address advance
// for every accepted packet.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   start_transfer       : level request; only its rising edge starts a transfer
//   dma_transfer         : total length in bytes (captured at start)
//   r_key, rem_qpn,
//   loc_psn, rem_addr    : transfer metadata (captured at start)
//   m_pkt_valid/ready    : descriptor handshake
//   m_pkt_opcode         : BTH opcode 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST, 0x0A ONLY
//   m_pkt_psn, m_pkt_dest_qpn, m_pkt_r_key, m_pkt_vaddr,
//   m_pkt_dma_length, m_pkt_reth_valid, m_pkt_payload_len : descriptor fields
//   busy                 : transfer in progress (ISSUE or DONE)
//   done                 : one-cycle pulse after the final handshake
//   next_psn             : PSN that follows the last packet sent
// ---------------------------------------------------------------------------
module roce_tx_transfer_scheduler #(
    parameter int PMTU_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_transfer,
    input  logic [31:0] dma_transfer,
    input  logic [31:0] r_key,
    input  logic [23:0] rem_qpn,
    input  logic [23:0] loc_psn,
    input  logic [63:0] rem_addr,
    output logic        m_pkt_valid,
    input  logic        m_pkt_ready,
    output logic [7:0]  m_pkt_opcode,
    output logic [23:0] m_pkt_psn,
    output logic [23:0] m_pkt_dest_qpn,
    output logic [31:0] m_pkt_r_key,
    output logic [63:0] m_pkt_vaddr,
    output logic [31:0] m_pkt_dma_length,
    output logic        m_pkt_reth_valid,
    output logic [15:0] m_pkt_payload_len,
    output logic        busy,
    output logic        done,
    output logic [23:0] next_psn
);

    localparam logic [31:0] PMTU_BYTES = 32'd1 << PMTU_SHIFT;
    localparam logic [7:0]  OP_FIRST   = 8'h06;
    localparam logic [7:0]  OP_MIDDLE  = 8'h07;
    localparam logic [7:0]  OP_LAST    = 8'h08;
    localparam logic [7:0]  OP_ONLY    = 8'h0A;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

    state_t      state_reg;
    logic        start_prev_reg;
    logic [31:0] remaining_reg;
    logic        valid_reg;
    logic [7:0]  opcode_reg;
    logic [23:0] psn_reg;
    logic [23:0] qpn_reg;
    logic [31:0] rkey_reg;
    logic [63:0] vaddr_reg;
    logic [31:0] dma_len_reg;
    logic        reth_reg;
    logic [15:0] payload_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [23:0] next_psn_reg;

    logic        start_edge;
    logic        fire;
    logic        is_last;
    logic [31:0] src_rem;
    logic [63:0] src_addr;
    logic [23:0] src_psn;
    logic        src_first;
    logic [23:0] adv_psn;
    logic        fits;
    logic [15:0] payload_next;
    logic [7:0]  opcode_next;

    assign start_edge = start_transfer & ~start_prev_reg;
    assign fire       = valid_reg & m_pkt_ready;
    assign is_last    = (opcode_reg == OP_LAST) || (opcode_reg == OP_ONLY);
    assign adv_psn    = psn_reg + 24'd1;

    // The next descriptor is built from either the fresh start inputs (IDLE)
    // or the current packet advanced by its own payload (ISSUE), so a new
    // descriptor can be registered in the same edge as the handshake.
    always_comb begin
        src_rem   = remaining_reg - {16'd0, payload_reg};
        src_addr  = vaddr_reg + {48'd0, payload_reg};
        src_psn   = adv_psn;
        src_first = 1'b0;
        if (state_reg == ST_IDLE) begin
            src_rem   = dma_transfer;
            src_addr  = rem_addr;
            src_psn   = loc_psn;
            src_first = 1'b1;
        end
        fits         = (src_rem <= PMTU_BYTES);
        payload_next = fits ? src_rem[15:0] : PMTU_BYTES[15:0];
        if (src_first)
            opcode_next = fits ? OP_ONLY : OP_FIRST;
        else
            opcode_next = fits ? OP_LAST : OP_MIDDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            start_prev_reg <= 1'b0;
            remaining_reg  <= '0;
            valid_reg      <= 1'b0;
            opcode_reg     <= '0;
            psn_reg        <= '0;
            qpn_reg        <= '0;
            rkey_reg       <= '0;
            vaddr_reg      <= '0;
            dma_len_reg    <= '0;
            reth_reg       <= 1'b0;
            payload_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            next_psn_reg   <= '0;
        end else begin
            start_prev_reg <= start_transfer;
            done_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        qpn_reg       <= rem_qpn;
                        rkey_reg      <= r_key;
                        dma_len_reg   <= dma_transfer;
                        remaining_reg <= src_rem;
                        vaddr_reg     <= src_addr;
                        psn_reg       <= src_psn;
                        opcode_reg    <= opcode_next;
                        payload_reg   <= payload_next;
                        reth_reg      <= src_first;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fire) begin
                        if (is_last) begin
                            valid_reg    <= 1'b0;
                            done_reg     <= 1'b1;
                            next_psn_reg <= adv_psn;
                            state_reg    <= ST_DONE;
                        end else begin
                            remaining_reg <= src_rem;
                            vaddr_reg     <= src_addr;
                            psn_reg       <= src_psn;
                            opcode_reg    <= opcode_next;
                            payload_reg   <= payload_next;
                            reth_reg      <= src_first;
                        end
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign m_pkt_valid       = valid_reg;
    assign m_pkt_opcode      = opcode_reg;
    assign m_pkt_psn         = psn_reg;
    assign m_pkt_dest_qpn    = qpn_reg;
    assign m_pkt_r_key       = rkey_reg;
    assign m_pkt_vaddr       = vaddr_reg;
    assign m_pkt_dma_length  = dma_len_reg;
    assign m_pkt_reth_valid  = reth_reg;
    assign m_pkt_payload_len = payload_reg;
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign next_psn          = next_psn_reg;

endmodule

// File: doc/roce_tx_transfer_scheduler.md
ROCE_TX_TRANSFER_SCHEDULER -- requirements
Module: roce_tx_transfer_scheduler

Interface
REQ-001 SHALL have parameter PMTU_SHIFT, default 10, log2 of path MTU in bytes (legal 8..12, i.e. 256..4096).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_transfer  input  1  level request from connection manager (txmeta_start & metadata_valid).
REQ-005 SHALL have port dma_transfer  input  32  total transfer length in bytes, sampled at start.
REQ-006 SHALL have ports r_key  input  32, rem_qpn  input  24, loc_psn  input  24, rem_addr  input  64; all sampled at start.
REQ-007 SHALL have port m_pkt_valid  output  1  packet descriptor valid.
REQ-008 SHALL have port m_pkt_ready  input  1  downstream accepts descriptor.
REQ-009 SHALL have port m_pkt_opcode  output  8  BTH opcode: 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST, 0x0A ONLY.
REQ-010 SHALL have ports m_pkt_psn  output  24, m_pkt_dest_qpn  output  24, m_pkt_r_key  output  32.
REQ-011 SHALL have ports m_pkt_vaddr  output  64, running remote address; m_pkt_dma_length  output  32, total length for RETH.
REQ-012 SHALL have port m_pkt_reth_valid  output  1  high on FIRST/ONLY descriptors only.
REQ-013 SHALL have port m_pkt_payload_len  output  16  payload bytes of this packet.
REQ-014 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), next_psn  output  24.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DONE.
REQ-016 SHALL detect a start as the rising edge of start_transfer (registered previous value); a held-high level SHALL NOT retrigger.
REQ-017 In IDLE, on start edge at cycle N, SHALL capture all inputs, set remaining=dma_transfer, addr=rem_addr, psn=loc_psn, first=1, go to ISSUE; m_pkt_valid SHALL be high at N+1.
REQ-018 Start edges in ISSUE or DONE SHALL be ignored (not queued).
REQ-019 payload_len SHALL be min(remaining, 2^PMTU_SHIFT).
REQ-020 Opcode: first & remaining<=PMTU -> ONLY; first & remaining>PMTU -> FIRST; !first & remaining<=PMTU -> LAST; else MIDDLE.
REQ-021 dma_transfer=0 SHALL produce exactly one ONLY descriptor, payload_len 0, reth_valid 1.
REQ-022 All m_pkt_* SHALL be registered and stable while m_pkt_valid & !m_pkt_ready.
REQ-023 On handshake (valid & ready) SHALL: remaining-=payload_len, addr+=payload_len (64-bit, wraps mod 2^64), psn=(psn+1) mod 2^24, first=0; next descriptor valid the following cycle with no bubble required beyond one register stage.
REQ-024 On handshake of a LAST or ONLY descriptor SHALL deassert m_pkt_valid and enter DONE.
REQ-025 DONE SHALL last one cycle: done=1, next_psn=psn after final increment, then IDLE.
REQ-026 busy SHALL be 1 in ISSUE and DONE, 0 in IDLE.
REQ-027 PSN wrap 0xFFFFFF -> 0x000000 SHALL occur without affecting opcode sequencing.
REQ-028 m_pkt_dest_qpn, m_pkt_r_key, m_pkt_dma_length SHALL equal captured values for all packets of a transfer.

Reset
REQ-029 rst SHALL force IDLE, m_pkt_valid=0, done=0, busy=0, next_psn=0, start edge register=0, all descriptor outputs 0, in the cycle after rst sampled high.
REQ-030 rst mid-transfer SHALL abandon the transfer with no further descriptors; done SHALL NOT pulse.
REQ-031 start_transfer held high through reset release SHALL count as a rising edge on the first non-reset cycle.

Verification
REQ-032 PMTU 1024, len 3000, psn 0x000010, addr 0x1000, ready=1 -> FIRST/1024/psn 0x10/vaddr 0x1000, MIDDLE/1024/0x11/0x1400, LAST/952/0x12/0x1800; done; next_psn 0x13.
REQ-033 len 1024 -> single ONLY, payload 1024, reth_valid 1; len 1025 -> FIRST 1024, LAST 1.
REQ-034 len 0 -> one ONLY, payload_len 0, dma_length 0; done next cycle after handshake.
REQ-035 psn 0xFFFFFE, len 3072 -> PSNs 0xFFFFFE, 0xFFFFFF, 0x000000; next_psn 0x000001.
REQ-036 ready toggled randomly -> descriptors stable under stall, none lost or duplicated; second start edge during busy ignored.
REQ-037 rst asserted after FIRST handshake of len 4096 -> m_pkt_valid 0 next cycle, no done, new start then issues from captured new inputs.
